// File: rtl/if_axis_rx_pkg.sv
// Shared constants for the CPU-mapped AXI-stream receiver: register offsets,
// control/status bit positions and the default peripheral address window.
package if_axis_rx_pkg;

    localparam logic [7:0] DEF_SOC_SEGMENT = 8'he4;
    localparam logic [7:0] DEF_SOC_CLASS   = 8'haa;

    // Register select values taken from addr_i[6:4].
    typedef enum logic [2:0] {
        REG_STATUS  = 3'b001,
        REG_CONTROL = 3'b010,
        REG_DATA    = 3'b011
    } reg_sel_e;

    localparam int CTRL_POP   = 0;
    localparam int CTRL_FLUSH = 1;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_TREADY    = 2;
    localparam int STAT_COUNT_LSB = 8;

    function automatic logic [31:0] status_word(input logic [7:0] count,
                                                input logic       tready,
                                                input logic       full,
                                                input logic       not_empty);
        logic [31:0] w;
        w = '0;
        w[STAT_COUNT_LSB +: 8] = count;
        w[STAT_TREADY]         = tready;
        w[STAT_FULL]           = full;
        w[STAT_NOT_EMPTY]      = not_empty;
        return w;
    endfunction

endpackage

// File: rtl/if_axis_rx_sync_fifo.sv
// Single-clock FIFO with synchronous reset and flush; head data is shown
// combinationally (first-word fall-through style), pointers wrap modulo DEPTH.
module if_axis_rx_sync_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int ADDR_BITS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_push,
    input  logic [WIDTH-1:0]     i_data,
    input  logic                 i_pop,
    input  logic                 i_flush,
    output logic [WIDTH-1:0]     o_head,
    output logic [ADDR_BITS:0]   o_count,
    output logic                 o_full,
    output logic                 o_empty
);

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [ADDR_BITS-1:0] r_head;
    logic [ADDR_BITS-1:0] r_tail;
    logic [ADDR_BITS:0]   r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign o_full    = (r_count == (ADDR_BITS+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_head];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_tail <= r_tail + ADDR_BITS'(1);
            if (w_pop_ok)  r_head <= r_head + ADDR_BITS'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (ADDR_BITS+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_BITS+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage carries no reset; entries are only visible once the
    // pointers say they were written, so clearing them buys nothing.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_tail] <= i_data;
    end

endmodule

// File: rtl/if_axis_rx.sv
// AXI-stream slave that buffers incoming beats in a FIFO and exposes status,
// head data and pop/flush control through a CPU register window.
module if_axis_rx
    import if_axis_rx_pkg::*;
#(
    parameter logic [7:0] SOC_SEGMENT     = DEF_SOC_SEGMENT,
    parameter logic [7:0] SOC_CLASS       = DEF_SOC_CLASS,
    parameter int         AXIS_DATA_WIDTH = 8,
    parameter int         FIFO_DEPTH      = 8,
    parameter int         FIFO_ADDR_BITS  = 3
) (
    input  logic                       axis_aclk_i,
    input  logic                       axis_areset_i,
    input  logic [31:0]                addr_i,
    input  logic [31:0]                data_i,
    output logic [31:0]                data_o,
    output logic                       data_access_o,
    input  logic                       data_w_i,
    input  logic                       s_axis_tvalid_i,
    output logic                       s_axis_tready_o,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata_i
);

    logic                       w_access;
    logic [2:0]                 w_sel;
    logic                       w_ctrl_wr;
    logic                       w_pop;
    logic                       w_flush;
    logic                       w_push;
    logic [AXIS_DATA_WIDTH-1:0] w_head;
    logic [FIFO_ADDR_BITS:0]    w_count;
    logic [7:0]                 w_count8;
    logic                       w_full;
    logic                       w_empty;
    logic [31:0]                w_rd_mux;
    logic [31:0]                r_data;
    logic                       w_unused;

    assign w_access      = (addr_i[31:24] == SOC_SEGMENT) && (addr_i[23:16] == SOC_CLASS);
    assign data_access_o = w_access;
    assign w_sel         = addr_i[6:4];

    assign w_ctrl_wr = w_access && data_w_i && (w_sel == REG_CONTROL);
    assign w_pop     = w_ctrl_wr && data_i[CTRL_POP];
    assign w_flush   = w_ctrl_wr && data_i[CTRL_FLUSH];

    // Ready comes only from the registered count, so a same-cycle pop never
    // opens the door while full.
    assign s_axis_tready_o = !w_full;
    assign w_push          = s_axis_tvalid_i && s_axis_tready_o;

    if_axis_rx_sync_fifo #(
        .WIDTH     (AXIS_DATA_WIDTH),
        .DEPTH     (FIFO_DEPTH),
        .ADDR_BITS (FIFO_ADDR_BITS)
    ) u_fifo (
        .clk     (axis_aclk_i),
        .rst     (axis_areset_i),
        .i_push  (w_push),
        .i_data  (s_axis_tdata_i),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_count8 = 8'(w_count);

    // NOTE: the read mux gets a default before the case so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        w_rd_mux = '0;
        case (w_sel)
            REG_STATUS: w_rd_mux = status_word(w_count8, s_axis_tready_o, w_full, !w_empty);
            REG_DATA:   if (!w_empty) w_rd_mux[AXIS_DATA_WIDTH-1:0] = w_head;
            default:    w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge axis_aclk_i) begin
        if (axis_areset_i) begin
            r_data <= '0;
        end else if (w_access) begin
            r_data <= w_rd_mux;
        end
    end

    assign data_o = r_data;

    assign w_unused = &{1'b0, addr_i[15:7], addr_i[3:0], data_i[31:2]};

endmodule

// File: tb/tb_if_axis_rx.sv
// Directed self-checking bench for if_axis_rx: register reads, backpressure,
// push/pop overlap, pointer wrap, flush and mid-run reset.
module tb_if_axis_rx;

    localparam logic [31:0] A_STATUS  = 32'he4aa0010;
    localparam logic [31:0] A_CONTROL = 32'he4aa0020;
    localparam logic [31:0] A_DATA    = 32'he4aa0030;
    localparam logic [31:0] A_OTHER   = 32'he4aa0040;
    localparam logic [31:0] A_OFF     = 32'h00000000;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        access;
    logic        data_w;
    logic        tvalid;
    logic        tready;
    logic [7:0]  tdata;

    int n_cmp;
    int n_bad;

    logic [31:0] rd;
    logic [7:0]  q[$];
    logic [7:0]  exp_b;

    if_axis_rx dut (
        .axis_aclk_i     (clk),
        .axis_areset_i   (rst),
        .addr_i          (addr),
        .data_i          (wdata),
        .data_o          (rdata),
        .data_access_o   (access),
        .data_w_i        (data_w),
        .s_axis_tvalid_i (tvalid),
        .s_axis_tready_o (tready),
        .s_axis_tdata_i  (tdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
        addr   = a;
        data_w = 1'b0;
        tick();
        d    = rdata;
        addr = A_OFF;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        addr   = a;
        wdata  = d;
        data_w = 1'b1;
        tick();
        data_w = 1'b0;
        wdata  = '0;
        addr   = A_OFF;
    endtask

    task automatic push_beat(input logic [7:0] d);
        int n;
        n      = 0;
        tvalid = 1'b1;
        tdata  = d;
        while (!tready && n < 50) begin
            tick();
            n++;
        end
        check($sformatf("push_ready_%02h", d), {31'b0, tready}, 32'd1);
        tick();
        tvalid = 1'b0;
    endtask

    task automatic read_pop(input string tag, input logic [7:0] exp);
        cpu_read(A_DATA, rd);
        check(tag, rd, {24'b0, exp});
        cpu_write(A_CONTROL, 32'h1);
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst    = 1'b1;
        addr   = A_OFF;
        wdata  = '0;
        data_w = 1'b0;
        tvalid = 1'b0;
        tdata  = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state and decode
        check("rst_tready", {31'b0, tready}, 32'd1);
        check("rst_data_o", rdata, 32'h0);
        check("decode_off", {31'b0, access}, 32'd0);
        addr = 32'he4ab0010;
        #1;
        check("decode_bad_class", {31'b0, access}, 32'd0);
        addr = A_STATUS;
        #1;
        check("decode_hit", {31'b0, access}, 32'd1);
        cpu_read(A_STATUS, rd);
        check("rst_status", rd, 32'h00000004);
        cpu_read(A_DATA, rd);
        check("rst_data_empty", rd, 32'h0);
        cpu_read(A_STATUS, rd);
        tick();
        tick();
        check("data_o_hold", rdata, 32'h00000004);
        cpu_read(A_OTHER, rd);
        check("other_offset", rd, 32'h0);
        cpu_read(A_CONTROL, rd);
        check("control_reads_0", rd, 32'h0);

        // Basic push / pop
        push_beat(8'h11);
        push_beat(8'h22);
        push_beat(8'h33);
        cpu_read(A_STATUS, rd);
        check("status_3", rd, 32'h00000305);
        read_pop("data_11", 8'h11);
        read_pop("data_22", 8'h22);
        cpu_write(A_CONTROL, 32'h1);
        cpu_read(A_STATUS, rd);
        check("status_drained", rd, 32'h00000004);

        // Fill to full with tvalid held, then backpressure on the 9th beat
        tvalid = 1'b1;
        tdata  = 8'ha0;
        for (int i = 0; i < 8; i++) begin
            tick();
            tdata = 8'(8'ha1 + i);
        end
        check("full_tready", {31'b0, tready}, 32'd0);
        cpu_read(A_STATUS, rd);
        check("status_full", rd, 32'h00000803);
        tick();
        check("full_hold_tready", {31'b0, tready}, 32'd0);
        cpu_write(A_CONTROL, 32'h1);
        cpu_read(A_DATA, rd);
        check("after_pop_a1", rd, 32'h000000a1);
        tvalid = 1'b0;
        cpu_read(A_STATUS, rd);
        check("status_refull", rd, 32'h00000803);
        for (int k = 0; k < 8; k++)
            read_pop($sformatf("drain_a%0d", k + 1), 8'(8'ha1 + k));
        cpu_read(A_STATUS, rd);
        check("status_empty2", rd, 32'h00000004);

        // Simultaneous push and pop at count 4
        push_beat(8'h41);
        push_beat(8'h42);
        push_beat(8'h43);
        push_beat(8'h44);
        check("pp_tready", {31'b0, tready}, 32'd1);
        tvalid = 1'b1;
        tdata  = 8'h45;
        addr   = A_CONTROL;
        wdata  = 32'h1;
        data_w = 1'b1;
        tick();
        tvalid = 1'b0;
        data_w = 1'b0;
        addr   = A_OFF;
        cpu_read(A_STATUS, rd);
        check("pp_status", rd, 32'h00000405);
        read_pop("pp_42", 8'h42);
        read_pop("pp_43", 8'h43);
        read_pop("pp_44", 8'h44);
        read_pop("pp_45", 8'h45);

        // 20 beats with interleaved pops, tail wraps more than twice
        for (int i = 0; i < 20; i++) begin
            push_beat(8'(8'h60 + i));
            q.push_back(8'(8'h60 + i));
            if (q.size() >= 3) begin
                exp_b = q.pop_front();
                read_pop($sformatf("wrap_%02h", exp_b), exp_b);
            end
        end
        while (q.size() > 0) begin
            exp_b = q.pop_front();
            read_pop($sformatf("wrap_%02h", exp_b), exp_b);
        end
        cpu_read(A_STATUS, rd);
        check("wrap_empty", rd, 32'h00000004);

        // Flush (with concurrent pop bit) discards a same-cycle beat
        for (int i = 0; i < 5; i++) push_beat(8'(8'h51 + i));
        cpu_read(A_STATUS, rd);
        check("pre_flush_status", rd, 32'h00000505);
        tvalid = 1'b1;
        tdata  = 8'h5a;
        addr   = A_CONTROL;
        wdata  = 32'h3;
        data_w = 1'b1;
        tick();
        tvalid = 1'b0;
        data_w = 1'b0;
        addr   = A_OFF;
        cpu_read(A_STATUS, rd);
        check("flush_status", rd, 32'h00000004);
        cpu_read(A_DATA, rd);
        check("flush_data", rd, 32'h0);
        cpu_write(A_CONTROL, 32'h1);
        cpu_read(A_STATUS, rd);
        check("pop_empty_status", rd, 32'h00000004);
        push_beat(8'h77);
        read_pop("post_flush_77", 8'h77);

        // Reset mid-operation
        push_beat(8'h81);
        push_beat(8'h82);
        push_beat(8'h83);
        cpu_read(A_STATUS, rd);
        check("pre_rst_status", rd, 32'h00000305);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_data_o", rdata, 32'h0);
        check("mid_rst_tready", {31'b0, tready}, 32'd1);
        cpu_read(A_STATUS, rd);
        check("mid_rst_status", rd, 32'h00000004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_axis_rx.md
Name: if_axis_rx

Overview:
- Memory-mapped AXI-stream slave (receiver) for the CPU bus.
- Accepts beats from an external AXI-stream master into an internal FIFO.
- Exposes FIFO status, head data and pop/flush control as CPU-visible registers in the SoC peripheral segment.
- Receive-side counterpart of the CPU-driven AXI-stream transmitter; same bus protocol and register-window style.

Parameters:
- SOC_SEGMENT, 'He4: addr_i[31:24] match value.
- SOC_CLASS, 'Haa: addr_i[23:16] match value; peripheral base is 0xe4aa0000.
- AXIS_DATA_WIDTH, 8: tdata width; legal range 1..16.
- FIFO_DEPTH, 8: entries; must be a power of two, 2..128.
- FIFO_ADDR_BITS, 3: log2(FIFO_DEPTH).

Ports:
- axis_aclk_i  in  1  single clock; everything is rising-edge.
- axis_areset_i  in  1  synchronous, active-high reset.
- addr_i  in  32  CPU address.
- data_i  in  32  CPU write data.
- data_o  out  32  CPU read data (registered).
- data_access_o  out  1  high when addr_i selects this peripheral.
- data_w_i  in  1  CPU write strobe.
- s_axis_tvalid_i  in  1  upstream beat valid.
- s_axis_tready_o  out  1  block can accept a beat.
- s_axis_tdata_i  in  AXIS_DATA_WIDTH  upstream beat data.

Behaviour:
- Decode (combinational):
  - access = (addr_i[31:24]==SOC_SEGMENT) && (addr_i[23:16]==SOC_CLASS).
  - data_access_o = access.
  - Register select = addr_i[6:4].
- Register map:
  - 0x10 STATUS (RO): bits [15:8] = count; [2] = s_axis_tready_o; [1] = full; [0] = not_empty; other bits 0.
  - 0x20 CONTROL (WO): write with data_i[0]=1 pops one entry; data_i[1]=1 flushes; reads return 0.
  - 0x30 DATA (RO): bits [AXIS_DATA_WIDTH-1:0] = FIFO head; other bits 0; returns 0 when empty. Reading does not pop.
  - Any other offset reads 0.
- Reads:
  - data_o is registered and updates on the edge after access=1 with the value selected by addr_i[6:4].
  - data_o holds its last value while access=0.
  - Read latency is 1 cycle.
- Ingress:
  - s_axis_tready_o = !full, combinational from registered count.
  - A beat transfers on an edge where tvalid && tready: it is written at the tail, and the tail pointer and count update on that edge.
  - No bypass: while full, tready=0 even if a pop occurs in the same cycle.
  - The block never drops a handshaken beat, except in the flush case below.
- Pop:
  - A CPU write to 0x20 with data_i[0]=1 while not empty advances the head and decrements count.
  - A pop while empty is ignored: no pointer or count change, no underflow.
- Simultaneous push and pop: head and tail both advance; count is unchanged.
- Flush:
  - Write to 0x20 with data_i[1]=1 sets head, tail and count to 0 on the next edge.
  - Flush overrides a concurrent pop.
  - A beat handshaken in the flush cycle is discarded.
- Wrap-around: pointers are FIFO_ADDR_BITS wide and wrap modulo FIFO_DEPTH. count is FIFO_ADDR_BITS+1 bits, range 0..FIFO_DEPTH. full = (count==FIFO_DEPTH).
- Reset (synchronous, active-high):
  - data_o=0; head, tail and count = 0.
  - Hence s_axis_tready_o=1 on the first cycle after reset release.
  - FIFO storage is not reset.
  - Reset asserted mid-operation discards all contents on that edge.
- Width rules:
  - Stored data is s_axis_tdata_i as-is.
  - Zero-extend to 32 bits on read.
  - count is zero-extended into STATUS[15:8].

Decomposition:
- Shared package:
  - Register offset constants: STATUS=3'b001, CONTROL=3'b010, DATA=3'b011.
  - CONTROL bit indices: POP=0, FLUSH=1.
  - STATUS bit indices.
  - Default SOC_SEGMENT/SOC_CLASS values.
- One sub-module, sync_fifo:
  - Parameterised WIDTH/DEPTH/ADDR_BITS.
  - Provides push, pop, flush, head data, count, full and empty.
  - if_axis_rx keeps the decode, register read mux and control strobe generation.

Test Plan:
- Reset then idle -> s_axis_tready_o=1; STATUS read at 0xe4aa0010 returns 0x00000004; DATA read returns 0x00000000.
- Push beats 0x11, 0x22, 0x33 -> STATUS=0x00000305; DATA=0x00000011; pop; DATA=0x00000022; pop, pop -> STATUS=0x00000004.
- Push 8 beats 0xA0..0xA7 with tvalid held high -> after the 8th, tready=0 and STATUS=0x00000803 (full, not empty, tready low); 9th beat 0xA8 held with tvalid high is not accepted until after a pop; next DATA=0xA1 after one pop; 0xA8 is eventually read out last.
- Pop issued on the same edge as a handshaken push with count=4 -> count stays 4; data order preserved.
- Ingress 20 beats with interleaved pops, crossing the pointer wrap twice -> output sequence equals input sequence.
- Flush with count=5 and a beat 0x5A handshaken in the same cycle -> STATUS=0x00000004, 0x5A not stored; a following pop on empty leaves STATUS unchanged; reset asserted with count=3 -> count 0 next cycle.
